// File: rtl/reg_bank_if.sv
// Register bank access bundle: one write port and two read ports.
interface reg_bank_if #(
  parameter int unsigned DATA_W = 32
);
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/reg_bank.sv
// 32x32 MIPS register bank: $0 hardwired to zero, $sp preset on reset,
// registered reads with same-edge write-to-read bypass.
module reg_bank #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 227
) (
  input  logic        clk,
  input  logic        reset,
  reg_bank_if.slave   bus
);

  localparam logic [4:0] SpIdx = 5'd29;

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              wr_en;

  assign wr_en = bus.RegWrite && (bus.WriteReg != 5'd0);

  // Pending write data takes priority over the stored value.
  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx == 5'd0) begin
      val = '0;
    end else if (wr_en && (bus.WriteReg == idx)) begin
      val = bus.WriteData;
    end else begin
      val = regs_q[idx];
    end
    return val;
  endfunction

  always_comb begin
    rd1_d = read_port(bus.ReadReg1);
    rd2_d = read_port(bus.ReadReg2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == int'(SpIdx)) ? SP_INIT : '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[bus.WriteReg] <= bus.WriteData;
      end
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign bus.ReadData1 = rd1_q;
  assign bus.ReadData2 = rd2_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank.
module tb_reg_bank;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reg_bank_if #(.DATA_W(32)) bus ();

  reg_bank #(
    .DATA_W (32),
    .SP_INIT(32'd227)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite  = we;
    bus.WriteReg  = wr;
    bus.WriteData = wd;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 5'd29, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_rd1", bus.ReadData1, 32'd0);
    check("in_reset_rd2", bus.ReadData2, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset values
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
    step();
    check("reset_sp", bus.ReadData1, 32'd227);
    check("reset_r5", bus.ReadData2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd31);
    step();
    check("reset_r3_no_write", bus.ReadData1, 32'd0);
    check("reset_r31", bus.ReadData2, 32'd0);

    // Basic write/read
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2);
    step();
    drive(1'b0, 5'd8, 32'h0, 5'd1, 5'd8);
    step();
    check("wr_rd_r8", bus.ReadData2, 32'hDEAD_BEEF);
    check("rd_r1_zero", bus.ReadData1, 32'd0);

    // $0 protection
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    step();
    check("r0_bypass_rd1", bus.ReadData1, 32'd0);
    check("r0_bypass_rd2", bus.ReadData2, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    check("r0_stored_rd1", bus.ReadData1, 32'd0);
    check("r0_stored_rd2", bus.ReadData2, 32'd0);

    // Bypass on both ports
    drive(1'b1, 5'd31, 32'hCAFE_0001, 5'd31, 5'd31);
    step();
    check("bypass_rd1", bus.ReadData1, 32'hCAFE_0001);
    check("bypass_rd2", bus.ReadData2, 32'hCAFE_0001);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd8);
    step();
    check("r31_stored", bus.ReadData1, 32'hCAFE_0001);
    check("r8_still", bus.ReadData2, 32'hDEAD_BEEF);

    // Back-to-back writes to one index
    drive(1'b1, 5'd7, 32'h0000_00A1, 5'd7, 5'd6);
    step();
    check("b2b_first", bus.ReadData1, 32'h0000_00A1);
    drive(1'b1, 5'd7, 32'h0000_00B2, 5'd6, 5'd7);
    step();
    check("b2b_second", bus.ReadData2, 32'h0000_00B2);
    check("b2b_other", bus.ReadData1, 32'd0);
    drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    step();
    check("b2b_last_wins", bus.ReadData1, 32'h0000_00B2);

    // Write with RegWrite low is ignored
    drive(1'b0, 5'd9, 32'h5555_AAAA, 5'd9, 5'd9);
    step();
    check("no_we_bypass", bus.ReadData1, 32'd0);
    step();
    check("no_we_stored", bus.ReadData2, 32'd0);

    // $sp overwrite, then reset restores it
    drive(1'b1, 5'd29, 32'h0000_00E0, 5'd29, 5'd0);
    step();
    check("sp_write_bypass", bus.ReadData1, 32'h0000_00E0);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd29);
    step();
    check("sp_write_stored", bus.ReadData2, 32'h0000_00E0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("sp_rst_rd2_zero", bus.ReadData2, 32'd0);
    #2;
    reset = 1'b1;
    step();
    check("sp_restored", bus.ReadData2, 32'd227);

    // Async reset mid-operation
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    step();
    check("pre_rst_rd1", bus.ReadData1, 32'hDEAD_BEEF);
    check("pre_rst_rd2", bus.ReadData2, 32'hDEAD_BEEF);
    #2;
    reset = 1'b0;
    #1;
    check("async_rd1_zero", bus.ReadData1, 32'd0);
    check("async_rd2_zero", bus.ReadData2, 32'd0);
    #1;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd29);
    step();
    check("post_rst_r8", bus.ReadData1, 32'd0);
    check("post_rst_sp", bus.ReadData2, 32'd227);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
